// File: rtl/pll_drp_responder.sv
// rtl/pll_drp_responder.sv - DRP responder emulating PLL config registers, handshake timing and lock
module pll_drp_responder #(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 16,
  parameter int NUM_REGS    = 32,
  parameter int RDY_LATENCY = 3,
  parameter int LOCK_DELAY  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              den,
  input  logic              dwe,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] di,
  output logic [DATA_W-1:0] do_data,
  output logic              drdy,
  input  logic              pll_rst,
  output logic              locked,
  output logic              busy,
  output logic [2:0]        err
);

  localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int LCNT_W = $clog2(LOCK_DELAY + 1);
  localparam int AW1    = ADDR_W + 1;
  localparam logic [AW1-1:0]    REG_LIMIT = AW1'(NUM_REGS);
  localparam logic [3:0]        RDY_LOAD  = 4'(RDY_LATENCY - 1);
  localparam logic [LCNT_W-1:0] LOCK_LOAD = LCNT_W'(LOCK_DELAY - 1);

  typedef enum logic [1:0] {LK_HOLD, LK_COUNT, LK_LOCKED} lock_state_t;

  logic [DATA_W-1:0] regs [NUM_REGS];

  // transaction latched at acceptance
  logic              lat_we;
  logic              lat_ok;
  logic [IDX_W-1:0]  lat_idx;
  logic [DATA_W-1:0] lat_di;
  logic [3:0]        rdy_cnt;

  // transaction being completed this edge
  logic              in_range;
  logic              accept;
  logic              finish_pend;
  logic              complete;
  logic              cur_we;
  logic              cur_ok;
  logic [IDX_W-1:0]  cur_idx;
  logic [DATA_W-1:0] cur_di;

  lock_state_t       lk_state, lk_state_d;
  logic [LCNT_W-1:0] lk_cnt, lk_cnt_d;

  // Decode acceptance and completion; with a latency of one the request completes on its own edge
  always_comb begin
    in_range    = ({1'b0, daddr} < REG_LIMIT);
    accept      = den && !busy;
    finish_pend = busy && (rdy_cnt == 4'd1);
    if (RDY_LATENCY == 1) begin
      complete = accept;
      cur_we   = dwe;
      cur_ok   = in_range;
      cur_idx  = daddr[IDX_W-1:0];
      cur_di   = di;
    end else begin
      complete = finish_pend;
      cur_we   = lat_we;
      cur_ok   = lat_ok;
      cur_idx  = lat_idx;
      cur_di   = lat_di;
    end
  end

  // DRP handshake, register file, read data and sticky error flags
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= DATA_W'(32'hA500 | i);
      end
      do_data <= '0;
      drdy    <= 1'b0;
      busy    <= 1'b0;
      err     <= 3'b000;
      rdy_cnt <= '0;
      lat_we  <= 1'b0;
      lat_ok  <= 1'b0;
      lat_idx <= '0;
      lat_di  <= '0;
    end else begin
      drdy <= complete;
      if (den && busy) begin
        err[0] <= 1'b1;
      end
      if (busy) begin
        rdy_cnt <= rdy_cnt - 4'd1;
      end
      if (finish_pend) begin
        busy <= 1'b0;
      end
      if (accept) begin
        lat_we  <= dwe;
        lat_ok  <= in_range;
        lat_idx <= daddr[IDX_W-1:0];
        lat_di  <= di;
        rdy_cnt <= RDY_LOAD;
        busy    <= (RDY_LATENCY > 1);
        if (dwe && !pll_rst) begin
          err[1] <= 1'b1;
        end
        if (!in_range) begin
          err[2] <= 1'b1;
        end
      end
      if (complete) begin
        if (cur_we) begin
          if (cur_ok) begin
            regs[cur_idx] <= cur_di;
          end
        end else begin
          do_data <= cur_ok ? regs[cur_idx] : '0;
        end
      end
    end
  end

  // Lock FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      lk_state <= LK_HOLD;
      lk_cnt   <= '0;
    end else begin
      lk_state <= lk_state_d;
      lk_cnt   <= lk_cnt_d;
    end
  end

  // Lock FSM next state: count down while pll_rst stays low, any pll_rst pulse restarts from HOLD
  always_comb begin
    lk_state_d = lk_state;
    lk_cnt_d   = lk_cnt;
    case (lk_state)
      LK_HOLD: begin
        if (!pll_rst) begin
          lk_state_d = LK_COUNT;
          lk_cnt_d   = LOCK_LOAD;
        end
      end
      LK_COUNT: begin
        if (pll_rst) begin
          lk_state_d = LK_HOLD;
        end else if (lk_cnt == '0) begin
          lk_state_d = LK_LOCKED;
        end else begin
          lk_cnt_d = lk_cnt - 1'b1;
        end
      end
      LK_LOCKED: begin
        if (pll_rst) begin
          lk_state_d = LK_HOLD;
        end
      end
      default: lk_state_d = LK_HOLD;
    endcase
  end

  // Lock FSM output: decoded straight from the state register
  always_comb begin
    locked = (lk_state == LK_LOCKED);
  end

endmodule

// File: tb/tb_pll_drp_responder.sv
// tb/tb_pll_drp_responder.sv - randomized and directed bench for pll_drp_responder against a behavioural model
module tb_pll_drp_responder;

  localparam int ADDR_W      = 7;
  localparam int DATA_W      = 16;
  localparam int NUM_REGS    = 32;
  localparam int RDY_LATENCY = 3;
  localparam int LOCK_DELAY  = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              den = 1'b0;
  logic              dwe = 1'b0;
  logic [ADDR_W-1:0] daddr = '0;
  logic [DATA_W-1:0] di = '0;
  logic              pll_rst = 1'b1;
  logic [DATA_W-1:0] do_data;
  logic              drdy;
  logic              locked;
  logic              busy;
  logic [2:0]        err;

  pll_drp_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS),
    .RDY_LATENCY(RDY_LATENCY), .LOCK_DELAY(LOCK_DELAY)
  ) dut (
    .clk(clk), .rst(rst), .den(den), .dwe(dwe), .daddr(daddr), .di(di),
    .do_data(do_data), .drdy(drdy), .pll_rst(pll_rst), .locked(locked),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: one pending request with an absolute due edge, lock = run of low pll_rst samples
  logic [DATA_W-1:0] m_regs [NUM_REGS];
  logic [DATA_W-1:0] m_do = '0;
  logic              m_drdy = 1'b0;
  logic              m_pend = 1'b0;
  logic              m_busy_pre = 1'b0;
  logic [2:0]        m_err = 3'b000;
  int                m_due = 0;
  int                m_edge = 0;
  int                m_low = 0;
  logic              m_we = 1'b0;
  int                m_addr = 0;
  logic [DATA_W-1:0] m_di = '0;

  task automatic m_finish;
    m_drdy = 1'b1;
    if (m_we) begin
      if (m_addr < NUM_REGS) m_regs[m_addr] = m_di;
    end else begin
      m_do = (m_addr < NUM_REGS) ? m_regs[m_addr] : '0;
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 16'hA500 | 16'(i);
      m_do   = '0;
      m_drdy = 1'b0;
      m_pend = 1'b0;
      m_err  = 3'b000;
      m_low  = 0;
    end else begin
      m_busy_pre = m_pend;
      m_drdy     = 1'b0;
      m_low      = pll_rst ? 0 : ((m_low < 100000) ? m_low + 1 : m_low);
      if (den && m_busy_pre) m_err[0] = 1'b1;
      if (m_pend && (m_edge == m_due)) begin
        m_finish();
        m_pend = 1'b0;
      end
      if (den && !m_busy_pre) begin
        m_we   = dwe;
        m_addr = int'(daddr);
        m_di   = di;
        if (dwe && !pll_rst) m_err[1] = 1'b1;
        if (m_addr >= NUM_REGS) m_err[2] = 1'b1;
        if (RDY_LATENCY == 1) begin
          m_finish();
        end else begin
          m_pend = 1'b1;
          m_due  = m_edge + RDY_LATENCY - 1;
        end
      end
    end
    m_edge++;
  end

  // Compare every output against the model just after each edge
  always @(posedge clk) begin
    #1;
    check("drdy", drdy, m_drdy);
    check("busy", busy, m_pend);
    check("do_data", do_data, m_do);
    check("err", err, m_err);
    check("locked", locked, (m_low >= LOCK_DELAY + 1));
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic drp(input logic we, input int addr, input logic [DATA_W-1:0] data, output int lat);
    den   = 1'b1;
    dwe   = we;
    daddr = ADDR_W'(addr);
    di    = data;
    lat   = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 1) den = 1'b0;
      if (drdy) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic count_drdy(input int cycles, output int n);
    n = 0;
    for (int k = 0; k < cycles; k++) begin
      tick();
      if (drdy) n++;
    end
  endtask

  task automatic wait_lock(output int n);
    n = 0;
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (locked) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    pll_rst = 1'b1;
    den = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    int lat;
    int n;

    repeat (3) tick();
    check("rst_err", err, 3'b000);
    check("rst_locked", locked, 1'b0);
    check("rst_do", do_data, 16'h0000);
    rst = 1'b0;
    tick();

    // read of reg 5 straight after reset
    drp(1'b0, 5, '0, lat);
    check("rd5_latency", lat, RDY_LATENCY);
    check("rd5_data", do_data, 16'hA505);

    // write then back-to-back read issued in the write's drdy cycle
    drp(1'b1, 8, 16'h1234, lat);
    check("wr8_latency", lat, RDY_LATENCY);
    drp(1'b0, 8, '0, lat);
    check("rd8_latency", lat, RDY_LATENCY);
    check("rd8_data", do_data, 16'h1234);
    check("rd8_err", err, 3'b000);

    // out-of-range write with pll_rst low, then out-of-range read
    pll_rst = 1'b0;
    drp(1'b1, 40, 16'hBEEF, lat);
    check("wr40_latency", lat, RDY_LATENCY);
    check("wr40_err", err, 3'b110);
    drp(1'b0, 40, '0, lat);
    check("rd40_data", do_data, 16'h0000);

    // den while busy is ignored
    do_reset();
    den = 1'b1; dwe = 1'b0; daddr = 7'd2;
    tick();
    dwe = 1'b1; daddr = 7'd9; di = 16'hFFFF;
    tick();
    den = 1'b0;
    count_drdy(10, n);
    check("viol_drdy_count", n, 1);
    check("viol_data", do_data, 16'hA502);
    check("viol_err", err, 3'b001);

    // lock after pll_rst release
    do_reset();
    repeat (5) tick();
    pll_rst = 1'b0;
    wait_lock(n);
    check("lock_edges", n, LOCK_DELAY + 1);

    // one-cycle pll_rst pulse mid-count restarts the lock delay
    do_reset();
    pll_rst = 1'b0;
    repeat (30) tick();
    check("lock_midcount", locked, 1'b0);
    pll_rst = 1'b1;
    tick();
    pll_rst = 1'b0;
    wait_lock(n);
    check("lock_after_pulse", n, LOCK_DELAY + 1);
    pll_rst = 1'b1;
    tick();
    check("unlock", locked, 1'b0);

    // reset aborts an outstanding write
    do_reset();
    den = 1'b1; dwe = 1'b1; daddr = 7'd1; di = 16'h0F0F;
    tick();
    den = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    count_drdy(6, n);
    check("abort_no_drdy", n, 0);
    check("abort_locked", locked, 1'b0);
    check("abort_err", err, 3'b000);
    drp(1'b0, 1, '0, lat);
    check("abort_rd1", do_data, 16'hA501);

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      rst   = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 99) == 0) pll_rst = ~pll_rst;
      den   = ($urandom_range(0, 2) == 0);
      dwe   = 1'($urandom_range(0, 1));
      daddr = ADDR_W'($urandom_range(0, 40));
      di    = 16'($urandom);
      tick();
    end
    rst = 1'b0;
    den = 1'b0;
    repeat (5) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
